fetch_pc_unit: RTL and testbench

//  Instruction-fetch PC generator with SRAM-like request/addr_ok/data_ok handshake for the MIPS core.

---
 rtl/fetch_pc_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Instruction-fetch PC generator with SRAM-like req/addr_ok/data_ok
//            handshake, one fetch outstanding, buffered branch/exception redirects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hbfc0_0000,
  parameter int                STEP         = 4,
  parameter int                EXC_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exception,
  input  logic [ADDR_W-1:0] exception_pc_i,
  input  logic              branch_enable_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [31:0]       inst_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic [EXC_W-1:0]  if_exc_type_o
);

  localparam logic [EXC_W-1:0]  C_EXC_ADDR_ERR = {1'b1, {(EXC_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] C_STEP         = ADDR_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend;
  logic              r_pend_valid;
  logic              r_discard;
  logic              r_req;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [31:0]       r_if_inst;
  logic [EXC_W-1:0]  r_if_exc;

  logic              w_slot_free;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_slot_free  = !r_if_valid || !stall;
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // A branch arriving on the completion cycle has not been buffered yet, so it wins directly.
  assign w_next_pc    = branch_enable_i ? branch_addr_i :
                        r_pend_valid    ? r_pend        : r_pc + C_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_VECTOR;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_discard    <= 1'b0;
      r_req        <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
      r_if_exc     <= '0;
    end else begin
      if (r_if_valid && !stall) begin
        r_if_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (exception) begin
            r_pc         <= exception_pc_i;
            r_pend_valid <= 1'b0;
          end else if (branch_enable_i) begin
            r_pc         <= branch_addr_i;
            r_pend_valid <= 1'b0;
          end else if (w_slot_free) begin
            if (w_misaligned) begin
              r_if_valid   <= 1'b1;
              r_if_pc      <= r_pc;
              r_if_inst    <= '0;
              r_if_exc     <= C_EXC_ADDR_ERR;
              r_pc         <= w_next_pc;
              r_pend_valid <= 1'b0;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end
          end
        end

        S_REQ: begin
          if (inst_addr_ok_i) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
          end
          // The request already on the bus must stay put; redirects are parked in pend.
          if (exception) begin
            r_pend       <= exception_pc_i;
            r_pend_valid <= 1'b1;
            r_discard    <= 1'b1;
          end else if (branch_enable_i && !r_discard) begin
            r_pend       <= branch_addr_i;
            r_pend_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (inst_data_ok_i) begin
            r_state      <= S_IDLE;
            r_discard    <= 1'b0;
            r_pend_valid <= 1'b0;
            if (exception) begin
              r_pc <= exception_pc_i;
            end else if (r_discard) begin
              r_pc <= r_pend;
            end else begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_inst  <= inst_rdata_i;
              r_if_exc   <= '0;
              r_pc       <= w_next_pc;
            end
          end else if (exception) begin
            r_pend       <= exception_pc_i;
            r_pend_valid <= 1'b1;
            r_discard    <= 1'b1;
          end else if (branch_enable_i && !r_discard) begin
            r_pend       <= branch_addr_i;
            r_pend_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase

      if (exception) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign inst_req_o    = r_req;
  assign inst_addr_o   = r_pc;
  assign if_valid_o    = r_if_valid;
  assign if_pc_o       = r_if_pc;
  assign if_inst_o     = r_if_inst;
  assign if_exc_type_o = r_if_exc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// Module   : tb_fetch_pc_unit
// Purpose  : Directed + randomized bench for fetch_pc_unit with a bus responder
//            and an instruction-stream reference model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst, stall, exception, branch_enable_i;
  logic [31:0] exception_pc_i, branch_addr_i;
  logic        inst_req_o, inst_addr_ok_i, inst_data_ok_i, if_valid_o;
  logic [31:0] inst_addr_o, inst_rdata_i, if_pc_o, if_inst_o, if_exc_type_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .exception      (exception),
    .exception_pc_i (exception_pc_i),
    .branch_enable_i(branch_enable_i),
    .branch_addr_i  (branch_addr_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o),
    .if_exc_type_o  (if_exc_type_o)
  );

  // Reference model: stream of fetched-but-not-yet-consumed PCs and the next PC the program flow expects.
  logic [31:0] q[$];
  logic [31:0] issue_log[$];
  int          issue_cyc[$];
  logic [31:0] exp_next, last_issue, last_consumed, out_addr, prev_addr;
  bit          counted, outstanding, prev_pending, rand_bus, exc_guard, force_dok;
  int          dcnt, dly, issue_cnt, deliv, cyc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_next     = RV;
    counted      = 1'b0;
    outstanding  = 1'b0;
    prev_pending = 1'b0;
    exc_guard    = 1'b0;
  endtask

  // One clock: observe at negedge, score, drive inputs for the next posedge.
  task automatic tick(input bit st, input bit exc, input logic [31:0] epc,
                      input bit br, input logic [31:0] ba);
    bit          aok, dok;
    logic [31:0] p;
    if (prev_pending) begin
      chk("req_held", {31'b0, inst_req_o}, 32'd1);
      chk("addr_stable", inst_addr_o, prev_addr);
    end
    if (inst_req_o && !counted) begin
      chk("issue_addr", inst_addr_o, exp_next);
      q.push_back(inst_addr_o);
      issue_log.push_back(inst_addr_o);
      issue_cyc.push_back(cyc);
      last_issue = inst_addr_o;
      issue_cnt++;
      exp_next  = inst_addr_o + 32'd4;
      counted   = 1'b1;
      exc_guard = 1'b0;
    end
    if (if_valid_o && !st && !exc && !rst) begin
      if (q.size() == 0) begin
        chk("consume_expected", 32'd0, 32'd1);
      end else begin
        p = q.pop_front();
        chk("if_pc", if_pc_o, p);
        chk("if_inst", if_inst_o, mem(p));
        chk("if_exc", if_exc_type_o, 32'd0);
        last_consumed = p;
        deliv++;
      end
    end
    dok = force_dok;
    if (outstanding) begin
      dcnt--;
      if (dcnt <= 0) begin
        dok = 1'b1;
        outstanding = 1'b0;
      end
    end
    aok = inst_req_o && (!rand_bus || ($urandom_range(0, 2) != 0));
    stall           = st;
    exception       = exc;
    exception_pc_i  = epc;
    branch_enable_i = br;
    branch_addr_i   = ba;
    inst_addr_ok_i  = aok;
    inst_data_ok_i  = dok;
    inst_rdata_i    = dok ? mem(out_addr) : $urandom;
    if (aok) begin
      counted     = 1'b0;
      outstanding = 1'b1;
      out_addr    = inst_addr_o;
      dcnt        = rand_bus ? int'($urandom_range(1, 3)) : dly;
    end
    prev_pending = inst_req_o && !aok;
    prev_addr    = inst_addr_o;
    if (rst) begin
      model_reset();
    end else if (exc) begin
      q.delete();
      exp_next  = epc;
      exc_guard = 1'b1;
    end else if (br) begin
      exp_next = ba;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick0();
    tick(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bit          st, ex, br;
    logic [31:0] ep, ba;
    rst = 1'b1; stall = 1'b0; exception = 1'b0; branch_enable_i = 1'b0;
    exception_pc_i = '0; branch_addr_i = '0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    rand_bus = 1'b0; force_dok = 1'b0; dly = 1;
    issue_cnt = 0; deliv = 0; cyc = 0; last_issue = '0; last_consumed = '0;
    out_addr = '0; prev_addr = '0; dcnt = 0;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, inst_req_o}, 32'd0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_exc", if_exc_type_o, 32'd0);
    rst = 1'b0;

    // Sequential fetch, one-cycle handshakes
    for (int i = 0; i < 30 && issue_cnt < 3; i++) tick0();
    chk("t1_addr0", issue_log[0], 32'hbfc0_0000);
    chk("t1_addr1", issue_log[1], 32'hbfc0_0004);
    chk("t1_addr2", issue_log[2], 32'hbfc0_0008);
    chk("t1_gap01", 32'(issue_cyc[1] - issue_cyc[0]), 32'd3);
    chk("t1_gap12", 32'(issue_cyc[2] - issue_cyc[1]), 32'd3);
    chk("t1_consumed", last_consumed, 32'hbfc0_0004);

    // Branch in WAIT: delay-slot fetch delivered, then target
    chk("t2_in_wait", {31'b0, outstanding}, 32'd1);
    tick(1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_1000);
    dly = 2;
    for (int i = 0; i < 20 && issue_cnt < 4; i++) tick0();
    chk("t2_target", last_issue, 32'h8000_1000);
    chk("t2_delay_slot", last_consumed, 32'hbfc0_0008);

    // Exception in WAIT: in-flight data dropped
    tick(1'b0, 1'b1, 32'hbfc0_0380, 1'b0, 32'd0);
    chk("t3_valid_a", {31'b0, if_valid_o}, 32'd0);
    tick0();
    chk("t3_valid_b", {31'b0, if_valid_o}, 32'd0);
    for (int i = 0; i < 20 && issue_cnt < 5; i++) tick0();
    chk("t3_handler", last_issue, 32'hbfc0_0380);
    chk("t3_no_deliver", last_consumed, 32'hbfc0_0008);

    // Branch to a misaligned target: tagged slot, no bus request
    tick(1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0002);
    tick0();
    tick0();
    chk("t4_consumed", last_consumed, 32'hbfc0_0380);
    chk("t4_valid", {31'b0, if_valid_o}, 32'd1);
    chk("t4_pc", if_pc_o, 32'h8000_0002);
    chk("t4_exc", if_exc_type_o, 32'h8000_0000);
    chk("t4_inst", if_inst_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("t4_no_req", {31'b0, inst_req_o}, 32'd0);
      chk("t4_hold", if_pc_o, 32'h8000_0002);
    end

    // Exception and branch together in IDLE: exception wins
    tick(1'b1, 1'b1, 32'hbfc0_0500, 1'b1, 32'h8000_2000);
    chk("t6_valid", {31'b0, if_valid_o}, 32'd0);
    for (int i = 0; i < 20 && issue_cnt < 6; i++) tick0();
    chk("t6_exc_wins", last_issue, 32'hbfc0_0500);

    // Stall with a full slot blocks new requests
    for (int i = 0; i < 20 && !if_valid_o; i++) tick0();
    chk("t5_slot_pc", if_pc_o, 32'hbfc0_0500);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      chk("t5_no_req", {31'b0, inst_req_o}, 32'd0);
    end
    for (int i = 0; i < 20 && issue_cnt < 7; i++) tick0();
    chk("t5_resume", last_issue, 32'hbfc0_0504);

    // Reset in WAIT, then a stray data_ok
    chk("t6_in_wait", {31'b0, outstanding}, 32'd1);
    rst = 1'b1;
    tick0();
    rst = 1'b0;
    chk("t6_rst_req", {31'b0, inst_req_o}, 32'd0);
    chk("t6_rst_valid", {31'b0, if_valid_o}, 32'd0);
    force_dok = 1'b1;
    tick0();
    force_dok = 1'b0;
    chk("t6_stray_valid", {31'b0, if_valid_o}, 32'd0);
    for (int i = 0; i < 20 && issue_cnt < 8; i++) tick0();
    chk("t6_rst_vec", last_issue, RV);

    // Randomized traffic
    rand_bus = 1'b1;
    deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 59) == 0);
      br = !ex && !exc_guard && ($urandom_range(0, 14) == 0);
      ep = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      ba = ($urandom_range(0, 7) == 0) ? 32'hffff_fffc : {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      tick(st, ex, ep, br, ba);
    end
    chk("liveness", {31'b0, deliv > 100}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
